// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared multiplier constants and state encoding
package mult_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_RUN     = RUN,
        ST_DONE    = DONE,
        ST_ILLEGAL = 2'b11
    } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_rca.sv
// rtl/shift_add_mult_ctrl_rca.sv - 8-bit ripple-carry adder shared by the multiplier
module shift_add_mult_ctrl_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W-1:0] S,
    output logic         Cout
);

    logic carry;

    // one full adder per bit, carry rippling from bit 0 upward
    always_comb begin
        carry = Cin;
        S     = '0;
        for (int i = 0; i < W; i++) begin
            S[i]  = A[i] ^ B[i] ^ carry;
            carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - sequential shift-and-add 8x8 multiplier controller
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH,
    parameter int CNT_W = mult_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // the shared adder is fixed at 8 bits and the counter must reach WIDTH
    if (WIDTH != 8 || (2 ** CNT_W) <= WIDTH) begin : g_bad_param
        $error("shift_add_mult_ctrl: WIDTH must be 8 and CNT_W must hold WIDTH");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               last_iter;

    assign add_b     = q[0] ? m : '0;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    shift_add_mult_ctrl_rca #(.W(WIDTH)) u_adder (
        .A    (acc),
        .B    (add_b),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    // state register; async reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and state-decoded outputs; illegal encoding falls back to idle
    always_comb begin
        state_nxt = ST_IDLE;
        busy      = 1'b0;
        done      = 1'b0;
        product   = '0;
        case (state)
            ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                busy      = 1'b1;
                state_nxt = last_iter ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done      = 1'b1;
                product   = {acc, q};
                state_nxt = ack ? ST_IDLE : ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // datapath: load operands on accept, one add-and-shift per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // carry-out lands in acc msb so no product bit is lost
                    {acc, q} <= {cout, sum, q[WIDTH-1:1]};
                    cnt      <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - self-checking bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];

    shift_add_mult_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input bit disturb,
                          output int nbusy, output logic [15:0] prod, output bit got_done);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        sb.push_back(16'(av) * 16'(bv));
        @(negedge clk);
        start = 1'b0;
        nbusy = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (disturb) begin
                a     = 8'($urandom);
                b     = 8'($urandom);
                start = 1'($urandom);
                ack   = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        ack = 1'b0;
        prod = product;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nb; logic [15:0] p; bit gd; logic [15:0] exp;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        run_op(8'h0D, 8'h0B, 1'b0, nb, p, gd);
        exp = sb.pop_front();
        checks++;
        if (!gd || nb != 8) begin
            failures++;
            $display("FAIL basic_latency: busy_cycles=%0d done_seen=%0d required 8 1", nb, gd);
        end
        checks++;
        if (p !== exp || p !== 16'h008F) begin
            failures++;
            $display("FAIL basic_product: product=%h required %h", p, exp);
        end
        do_ack();
        checks++;
        if (done !== 1'b0 || product !== 16'h0000) begin
            failures++;
            $display("FAIL basic_ack: done=%b product=%h required 0 0000", done, product);
        end
    endtask

    task automatic test_max();
        int nb; logic [15:0] p; bit gd; logic [15:0] exp;
        run_op(8'hFF, 8'hFF, 1'b0, nb, p, gd);
        exp = sb.pop_front();
        checks++;
        if (!gd || p !== exp || p !== 16'hFE01) begin
            failures++;
            $display("FAIL max_product: product=%h done_seen=%0d required %h", p, gd, exp);
        end
        do_ack();
    endtask

    task automatic test_zero_identity();
        logic [7:0] ta[3] = '{8'h00, 8'h01, 8'h80};
        logic [7:0] tb[3] = '{8'hC8, 8'hA5, 8'h02};
        int nb; logic [15:0] p; bit gd; logic [15:0] exp;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0, nb, p, gd);
            exp = sb.pop_front();
            checks++;
            if (!gd || nb != 8) begin
                failures++;
                $display("FAIL zid_latency[%0d]: busy_cycles=%0d done_seen=%0d required 8 1", i, nb, gd);
            end
            checks++;
            if (p !== exp) begin
                failures++;
                $display("FAIL zid_product[%0d]: product=%h required %h", i, p, exp);
            end
            do_ack();
        end
    endtask

    task automatic test_ignored_inputs();
        int nb; logic [15:0] p; bit gd; logic [15:0] exp;
        run_op(8'h12, 8'h34, 1'b1, nb, p, gd);
        exp = sb.pop_front();
        checks++;
        if (!gd || nb != 8) begin
            failures++;
            $display("FAIL ignored_latency: busy_cycles=%0d done_seen=%0d required 8 1", nb, gd);
        end
        checks++;
        if (p !== exp || p !== 16'h03A8) begin
            failures++;
            $display("FAIL ignored_product: product=%h required %h", p, exp);
        end
        do_ack();
    endtask

    task automatic test_done_handshake();
        int nb; logic [15:0] p; bit gd; logic [15:0] exp;
        int bad;
        run_op(8'h5A, 8'h3C, 1'b0, nb, p, gd);
        exp = sb.pop_front();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b1 || product !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL done_hold: unstable_cycles=%0d product=%h required 0 %h", bad, product, exp);
        end
        start = 1'b1;
        ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            failures++;
            $display("FAIL start_ack_same_edge: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL no_new_op: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int nb; logic [15:0] p; bit gd; logic [15:0] exp;
        @(negedge clk);
        a = 8'h55;
        b = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
            failures++;
            $display("FAIL async_abort: busy=%b done=%b product=%h required 0 0 0000", busy, done, product);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h07, 8'h06, 1'b0, nb, p, gd);
        exp = sb.pop_front();
        checks++;
        if (!gd || nb != 8 || p !== exp || p !== 16'h002A) begin
            failures++;
            $display("FAIL after_reset_product: product=%h busy_cycles=%0d required %h 8", p, nb, exp);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_identity();
        test_ignored_inputs();
        test_done_handshake();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
